// File: rtl/ir_tx_pkg.sv
// rtl/ir_tx_pkg.sv - shared state type, phase defaults and timing helpers for ir_frame_tx
package ir_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_S0_MARK,
    ST_S0_SPACE,
    ST_GAP_MARK,
    ST_GAP_SPACE,
    ST_S1_MARK,
    ST_S1_SPACE,
    ST_STOP_MARK,
    ST_REP_SPACE
  } ir_tx_state_e;

  localparam int unsigned DEF_LEAD_MARK_US   = 9000;
  localparam int unsigned DEF_LEAD_SPACE_US  = 4500;
  localparam int unsigned DEF_BIT_MARK_US    = 750;
  localparam int unsigned DEF_ZERO_SPACE_US  = 450;
  localparam int unsigned DEF_ONE_SPACE_US   = 1500;
  localparam int unsigned DEF_GAP_SPACE_US   = 20000;
  localparam int unsigned DEF_REPEAT_SPACE_US = 40000;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return us * (clk_hz / 1_000_000);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_mark(input ir_tx_state_e st);
    return st inside {ST_LEAD_MARK, ST_S0_MARK, ST_GAP_MARK, ST_S1_MARK, ST_STOP_MARK};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - carrier phase counter; phase is the value for the upcoming cycle
module ir_carrier_gen #(
  parameter int unsigned CAR_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  output logic [$clog2(CAR_DIV)-1:0] phase
);

  localparam int unsigned PW = $clog2(CAR_DIV);
  localparam logic [PW-1:0] LAST = PW'(CAR_DIV - 1);

  logic [PW-1:0] phase_q;

  // Exposing the next phase lets the owner register its carrier output in step with the envelope.
  always_comb begin
    phase = phase_q + 1'b1;
    if (restart || (phase_q == LAST)) begin
      phase = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase;
    end
  end

endmodule

// File: rtl/ir_frame_tx.sv
// rtl/ir_frame_tx.sv - pulse-distance IR frame transmitter with repeat and abort
module ir_frame_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned CARRIER_HZ      = 38_000,
  parameter int unsigned SEG0_BITS       = 35,
  parameter int unsigned SEG1_BITS       = 32,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter int unsigned REP_W           = 4,
  parameter int unsigned LEAD_MARK_US    = DEF_LEAD_MARK_US,
  parameter int unsigned LEAD_SPACE_US   = DEF_LEAD_SPACE_US,
  parameter int unsigned BIT_MARK_US     = DEF_BIT_MARK_US,
  parameter int unsigned ZERO_SPACE_US   = DEF_ZERO_SPACE_US,
  parameter int unsigned ONE_SPACE_US    = DEF_ONE_SPACE_US,
  parameter int unsigned GAP_SPACE_US    = DEF_GAP_SPACE_US,
  parameter int unsigned REPEAT_SPACE_US = DEF_REPEAT_SPACE_US
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       tx_valid,
  output logic                                       tx_ready,
  input  logic [SEG0_BITS-1:0]                       seg0_data,
  input  logic [((SEG1_BITS > 0) ? SEG1_BITS : 1)-1:0] seg1_data,
  input  logic [REP_W-1:0]                           tx_repeat,
  input  logic                                       tx_abort,
  output logic                                       tx_done,
  output logic                                       ir_env,
  output logic                                       ir_out
);

  localparam int unsigned CAR_DIV = CLK_HZ / CARRIER_HZ;
  localparam int unsigned CAR_PW  = $clog2(CAR_DIV);

  localparam int unsigned LEAD_MARK_C  = us_to_cycles(CLK_HZ, LEAD_MARK_US);
  localparam int unsigned LEAD_SPACE_C = us_to_cycles(CLK_HZ, LEAD_SPACE_US);
  localparam int unsigned BIT_MARK_C   = us_to_cycles(CLK_HZ, BIT_MARK_US);
  localparam int unsigned ZERO_C       = us_to_cycles(CLK_HZ, ZERO_SPACE_US);
  localparam int unsigned ONE_C        = us_to_cycles(CLK_HZ, ONE_SPACE_US);
  localparam int unsigned GAP_C        = us_to_cycles(CLK_HZ, GAP_SPACE_US);
  localparam int unsigned REP_C        = us_to_cycles(CLK_HZ, REPEAT_SPACE_US);
  localparam int unsigned MAX_C = max_u(max_u(max_u(LEAD_MARK_C, LEAD_SPACE_C), max_u(BIT_MARK_C, ZERO_C)),
                                        max_u(max_u(ONE_C, GAP_C), REP_C));
  localparam int unsigned CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] LEAD_MARK_M1  = CW'(LEAD_MARK_C - 1);
  localparam logic [CW-1:0] LEAD_SPACE_M1 = CW'(LEAD_SPACE_C - 1);
  localparam logic [CW-1:0] BIT_MARK_M1   = CW'(BIT_MARK_C - 1);
  localparam logic [CW-1:0] ZERO_M1       = CW'(ZERO_C - 1);
  localparam logic [CW-1:0] ONE_M1        = CW'(ONE_C - 1);
  localparam logic [CW-1:0] GAP_M1        = CW'(GAP_C - 1);
  localparam logic [CW-1:0] REP_M1        = CW'(REP_C - 1);

  localparam logic [CAR_PW-1:0] CAR_HALF = CAR_PW'(CAR_DIV / 2);

  localparam int unsigned S1_TOP = (SEG1_BITS > 0) ? SEG1_BITS - 1 : 0;
  localparam logic [5:0] S0_FIRST = MSB_FIRST ? 6'(SEG0_BITS - 1) : 6'd0;
  localparam logic [5:0] S0_LAST  = MSB_FIRST ? 6'd0 : 6'(SEG0_BITS - 1);
  localparam logic [5:0] S1_FIRST = MSB_FIRST ? 6'(S1_TOP) : 6'd0;
  localparam logic [5:0] S1_LAST  = MSB_FIRST ? 6'd0 : 6'(S1_TOP);

  if (CLK_HZ % 1_000_000 != 0) begin : g_bad_clk
    $error("ir_frame_tx: CLK_HZ must be a multiple of 1 MHz");
  end
  if (CAR_DIV < 2) begin : g_bad_car
    $error("ir_frame_tx: CLK_HZ / CARRIER_HZ must be at least 2");
  end
  if (SEG0_BITS < 1 || SEG0_BITS > 63 || SEG1_BITS > 63) begin : g_bad_seg
    $error("ir_frame_tx: segment lengths out of range");
  end

  ir_tx_state_e      state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     len_m1;
  logic [5:0]        bit_idx;
  logic [63:0]       seg0_q, seg1_q;
  logic [REP_W-1:0]  rep_cnt;
  logic              phase_done, cur_bit, last_bit, done_nxt, mark_nxt, car_restart;
  logic [CAR_PW-1:0] car_phase;

  assign tx_ready    = (state == ST_IDLE);
  assign phase_done  = (cnt == len_m1);
  assign mark_nxt    = is_mark(state_nxt);
  assign car_restart = mark_nxt && (state_nxt != state);

  // One bit index serves both segments; payloads are zero-padded so it indexes either directly.
  always_comb begin
    cur_bit  = (state == ST_S1_MARK || state == ST_S1_SPACE) ? seg1_q[bit_idx] : seg0_q[bit_idx];
    last_bit = (state == ST_S1_SPACE) ? (bit_idx == S1_LAST) : (bit_idx == S0_LAST);
  end

  always_comb begin
    case (state)
      ST_LEAD_MARK:                                      len_m1 = LEAD_MARK_M1;
      ST_LEAD_SPACE:                                     len_m1 = LEAD_SPACE_M1;
      ST_S0_MARK, ST_GAP_MARK, ST_S1_MARK, ST_STOP_MARK: len_m1 = BIT_MARK_M1;
      ST_S0_SPACE, ST_S1_SPACE:                          len_m1 = cur_bit ? ONE_M1 : ZERO_M1;
      ST_GAP_SPACE:                                      len_m1 = GAP_M1;
      ST_REP_SPACE:                                      len_m1 = REP_M1;
      default:                                           len_m1 = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (state == ST_IDLE) begin
      if (tx_valid) state_nxt = ST_LEAD_MARK;
    end else if (tx_abort) begin
      state_nxt = ST_IDLE;
    end else if (phase_done) begin
      case (state)
        ST_LEAD_MARK:  state_nxt = ST_LEAD_SPACE;
        ST_LEAD_SPACE: state_nxt = ST_S0_MARK;
        ST_S0_MARK:    state_nxt = ST_S0_SPACE;
        ST_S0_SPACE: begin
          if (!last_bit)            state_nxt = ST_S0_MARK;
          else if (SEG1_BITS == 0)  state_nxt = ST_STOP_MARK;
          else                      state_nxt = ST_GAP_MARK;
        end
        ST_GAP_MARK:   state_nxt = ST_GAP_SPACE;
        ST_GAP_SPACE:  state_nxt = ST_S1_MARK;
        ST_S1_MARK:    state_nxt = ST_S1_SPACE;
        ST_S1_SPACE:   state_nxt = last_bit ? ST_STOP_MARK : ST_S1_MARK;
        ST_STOP_MARK: begin
          if (rep_cnt != '0) begin
            state_nxt = ST_REP_SPACE;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        ST_REP_SPACE:  state_nxt = ST_LEAD_MARK;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  ir_carrier_gen #(
    .CAR_DIV (CAR_DIV)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (car_restart),
    .phase   (car_phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      seg0_q  <= '0;
      seg1_q  <= '0;
      rep_cnt <= '0;
      tx_done <= 1'b0;
      ir_env  <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_done <= done_nxt;
      ir_env  <= mark_nxt;
      ir_out  <= mark_nxt && (car_phase < CAR_HALF);
      cnt     <= (state_nxt != state || state == ST_IDLE) ? '0 : cnt + 1'b1;

      if (tx_valid && tx_ready) begin
        seg0_q  <= 64'(seg0_data);
        seg1_q  <= 64'(seg1_data);
        rep_cnt <= tx_repeat;
      end else if (state == ST_STOP_MARK && state_nxt == ST_REP_SPACE) begin
        rep_cnt <= rep_cnt - 1'b1;
      end

      if (state == ST_LEAD_SPACE && state_nxt == ST_S0_MARK) begin
        bit_idx <= S0_FIRST;
      end else if (state == ST_GAP_SPACE && state_nxt == ST_S1_MARK) begin
        bit_idx <= S1_FIRST;
      end else if ((state == ST_S0_SPACE && state_nxt == ST_S0_MARK) ||
                   (state == ST_S1_SPACE && state_nxt == ST_S1_MARK)) begin
        bit_idx <= MSB_FIRST ? bit_idx - 1'b1 : bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_frame_tx.sv
// tb/tb_ir_frame_tx.sv - scoreboard bench for ir_frame_tx at 1 us per cycle with shortened phases
module tb_ir_frame_tx;

  localparam int LM = 24;
  localparam int LS = 12;
  localparam int BM = 6;
  localparam int ZS = 3;
  localparam int OS = 9;
  localparam int GS = 40;
  localparam int RS = 60;

  typedef struct {
    logic  env;
    int    len;
    string tag;
  } ph_t;

  ph_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid, tx_ready, tx_abort, tx_done, ir_env, ir_out;
  logic [3:0] seg0_data;
  logic [2:0] seg1_data;
  logic [3:0] tx_repeat;
  logic       b_valid, b_ready, b_abort, b_done, b_env, b_out;
  logic [3:0] b_seg0;
  logic [0:0] b_seg1;
  logic [3:0] b_repeat;

  always #5 clk = ~clk;

  ir_frame_tx #(
    .CLK_HZ(1_000_000), .CARRIER_HZ(250_000), .SEG0_BITS(4), .SEG1_BITS(3), .MSB_FIRST(1'b1),
    .REP_W(4), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS),
    .ONE_SPACE_US(OS), .GAP_SPACE_US(GS), .REPEAT_SPACE_US(RS)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .seg0_data(seg0_data),
    .seg1_data(seg1_data), .tx_repeat(tx_repeat), .tx_abort(tx_abort), .tx_done(tx_done),
    .ir_env(ir_env), .ir_out(ir_out)
  );

  ir_frame_tx #(
    .CLK_HZ(1_000_000), .CARRIER_HZ(250_000), .SEG0_BITS(4), .SEG1_BITS(0), .MSB_FIRST(1'b0),
    .REP_W(4), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS),
    .ONE_SPACE_US(OS), .GAP_SPACE_US(GS), .REPEAT_SPACE_US(RS)
  ) dut_lsb (
    .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_ready(b_ready), .seg0_data(b_seg0),
    .seg1_data(b_seg1), .tx_repeat(b_repeat), .tx_abort(b_abort), .tx_done(b_done),
    .ir_env(b_env), .ir_out(b_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_ph(input logic env, input int len, input string tag);
    ph_t p;
    p.env = env;
    p.len = len;
    p.tag = tag;
    exp_q.push_back(p);
  endtask

  // Expected envelope as alternating mark/space runs, for every copy of the frame.
  task automatic push_expected(input logic [3:0] s0, input logic [2:0] s1, input int rep,
                               input bit msb, input int s1bits);
    logic b;
    for (int f = 0; f <= rep; f++) begin
      if (f > 0) push_ph(1'b0, RS, "rep_space");
      push_ph(1'b1, LM, "lead_mark");
      push_ph(1'b0, LS, "lead_space");
      for (int i = 0; i < 4; i++) begin
        b = msb ? s0[3-i] : s0[i];
        push_ph(1'b1, BM, "s0_mark");
        push_ph(1'b0, b ? OS : ZS, "s0_space");
      end
      if (s1bits > 0) begin
        push_ph(1'b1, BM, "gap_mark");
        push_ph(1'b0, GS, "gap_space");
        for (int i = 0; i < s1bits; i++) begin
          b = msb ? s1[s1bits-1-i] : s1[i];
          push_ph(1'b1, BM, "s1_mark");
          push_ph(1'b0, b ? OS : ZS, "s1_space");
        end
      end
      push_ph(1'b1, BM, "stop_mark");
    end
  endtask

  task automatic run_phases(input bit lsb, input int max_n);
    ph_t  p;
    int   n, bad_car, bad_ctl, k;
    logic env_v, out_v, e_out;
    k = 0;
    while (exp_q.size() > 0 && k < max_n) begin
      p = exp_q.pop_front();
      k++;
      n = 0;
      bad_car = 0;
      bad_ctl = 0;
      env_v = lsb ? b_env : ir_env;
      while (n < p.len + 4 && env_v === p.env) begin
        out_v = lsb ? b_out : ir_out;
        e_out = p.env & ((n % 4) < 2);
        if (out_v !== e_out) bad_car++;
        if ((lsb ? b_done : tx_done) !== 1'b0 || (lsb ? b_ready : tx_ready) !== 1'b0) bad_ctl++;
        n++;
        @(negedge clk);
        env_v = lsb ? b_env : ir_env;
      end
      check({p.tag, " length"}, n, p.len);
      check({p.tag, " carrier errors"}, bad_car, 0);
      check({p.tag, " done/ready errors"}, bad_ctl, 0);
    end
  endtask

  task automatic check_done(input bit lsb, input string tag);
    check({tag, " tx_done"}, lsb ? b_done : tx_done, 1);
    check({tag, " tx_ready"}, lsb ? b_ready : tx_ready, 1);
    check({tag, " ir_env idle"}, lsb ? b_env : ir_env, 0);
  endtask

  task automatic xfer(input logic [3:0] s0, input logic [2:0] s1, input logic [3:0] rep);
    tx_valid  = 1'b1;
    seg0_data = s0;
    seg1_data = s1;
    tx_repeat = rep;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    tx_valid = 0; tx_abort = 0; seg0_data = 0; seg1_data = 0; tx_repeat = 0;
    b_valid = 0; b_abort = 0; b_seg0 = 0; b_seg1 = 0; b_repeat = 0;
    repeat (3) @(negedge clk);
    check("reset tx_ready", tx_ready, 1);
    check("reset tx_done", tx_done, 0);
    check("reset ir_env", ir_env, 0);
    check("reset ir_out", ir_out, 0);
    check("reset lsb tx_ready", b_ready, 1);
    check("reset lsb ir_env", b_env, 0);
    rst = 1'b1;
    @(negedge clk);

    // Frame A; B's payload is then held valid throughout A and must be taken only when A completes.
    tx_valid = 1'b1; seg0_data = 4'b1010; seg1_data = 3'b011; tx_repeat = 4'd0;
    @(negedge clk);
    check("A tx_ready falls in cycle 1", tx_ready, 0);
    push_expected(4'b1010, 3'b011, 0, 1'b1, 3);
    seg0_data = 4'b0110; seg1_data = 3'b101; tx_repeat = 4'd2;
    run_phases(1'b0, 1000);
    check_done(1'b0, "A");
    push_expected(4'b0110, 3'b101, 2, 1'b1, 3);
    @(negedge clk);
    tx_valid = 1'b0;
    run_phases(1'b0, 1000);
    check_done(1'b0, "B");
    @(negedge clk);
    check("B done is one cycle", tx_done, 0);

    // Abort during the first S0 mark, then transfer with tx_abort still high in IDLE.
    xfer(4'b1111, 3'b000, 4'd1);
    repeat (39) @(negedge clk);
    check("C env before abort", ir_env, 1);
    tx_abort = 1'b1;
    @(negedge clk);
    check("abort ir_env", ir_env, 0);
    check("abort ir_out", ir_out, 0);
    check("abort tx_ready", tx_ready, 1);
    check("abort no tx_done", tx_done, 0);
    tx_valid = 1'b1; seg0_data = 4'b0001; seg1_data = 3'b110; tx_repeat = 4'd0;
    @(negedge clk);
    tx_valid = 1'b0; tx_abort = 1'b0;
    push_expected(4'b0001, 3'b110, 0, 1'b1, 3);
    run_phases(1'b0, 1000);
    check_done(1'b0, "D");
    @(negedge clk);
    check("D done is one cycle", tx_done, 0);

    // Reset in the middle of GAP_SPACE.
    xfer(4'b1100, 3'b010, 4'd0);
    push_expected(4'b1100, 3'b010, 0, 1'b1, 3);
    run_phases(1'b0, 11);
    repeat (GS / 2) @(negedge clk);
    check("E in gap space", ir_env, 0);
    #2 rst = 1'b0;
    #1;
    check("mid-frame reset tx_ready", tx_ready, 1);
    check("mid-frame reset tx_done", tx_done, 0);
    check("mid-frame reset ir_env", ir_env, 0);
    check("mid-frame reset ir_out", ir_out, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(4'b0101, 3'b100, 4'd1);
    push_expected(4'b0101, 3'b100, 1, 1'b1, 3);
    run_phases(1'b0, 1000);
    check_done(1'b0, "F");
    @(negedge clk);
    check("F done is one cycle", tx_done, 0);

    // LSB-first instance without segment 1.
    b_valid = 1'b1; b_seg0 = 4'b0001; b_seg1 = 1'b0; b_repeat = 4'd0;
    @(negedge clk);
    b_valid = 1'b0;
    push_expected(4'b0001, 3'b000, 0, 1'b0, 0);
    run_phases(1'b1, 1000);
    check_done(1'b1, "L");
    check("main dut idle during L", tx_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_frame_tx.md
# ir_frame_tx

Parametrised infrared frame transmitter for the air-conditioner remote datapath. It accepts a two-segment payload over a valid/ready handshake and sends it as a carrier-modulated pulse-distance frame: a lead burst, segment 0, a connect gap, segment 1, then a stop mark. It can repeat the frame and can be aborted mid-frame. It sits between the key/command logic and the IR LED driver pin.

## Interface
- CLK_HZ, 100_000_000: clock frequency; must be a multiple of 1 MHz (elaboration error otherwise)
- CARRIER_HZ, 38_000: carrier frequency; CAR_DIV = CLK_HZ/CARRIER_HZ, must be ≥ 2
- SEG0_BITS, 35: segment 0 length, 1..63
- SEG1_BITS, 32: segment 1 length, 0..63; 0 means no connect gap and no segment 1
- MSB_FIRST, 1: 1 sends bit [N-1] first; 0 sends bit [0] first
- REP_W, 4: width of the repeat count
- LEAD_MARK_US 9000, LEAD_SPACE_US 4500, BIT_MARK_US 750, ZERO_SPACE_US 450, ONE_SPACE_US 1500, GAP_SPACE_US 20000, REPEAT_SPACE_US 40000: phase durations
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- tx_valid  in  1  request to send
- tx_ready  out  1  high exactly while the state is IDLE
- seg0_data  in  SEG0_BITS  segment 0 payload, captured on transfer
- seg1_data  in  max(SEG1_BITS,1)  segment 1 payload, captured on transfer
- tx_repeat  in  REP_W  number of extra frame copies, captured on transfer
- tx_abort  in  1  terminates the transfer in progress
- tx_done  out  1  one-cycle pulse when a transfer completes normally
- ir_env  out  1  registered envelope, 1 = mark
- ir_out  out  1  registered modulated output to the LED driver

## Operation
- Each phase length in cycles is US·(CLK_HZ/1_000_000). Phase counters are sized by $clog2 of the largest phase.
- States: IDLE → LEAD_MARK → LEAD_SPACE → S0_MARK/S0_SPACE (per bit) → GAP_MARK → GAP_SPACE → S1_MARK/S1_SPACE (per bit) → STOP_MARK → (REP_SPACE → LEAD_MARK) or IDLE.
- A bit is BIT_MARK followed by ZERO_SPACE (bit = 0) or ONE_SPACE (bit = 1).
- GAP_MARK lasts BIT_MARK_US.
- If SEG1_BITS = 0, the last S0 bit goes directly to STOP_MARK.
- Transfer occurs when tx_valid & tx_ready. Payload and repeat count are registered in the transfer cycle. Inputs are ignored at all other times.
- Repeat: after STOP_MARK, if the remaining repeat count is > 0, decrement it and go to REP_SPACE, then LEAD_MARK. The frame is sent tx_repeat+1 times in total.
- Abort: in any non-IDLE state, tx_abort forces IDLE on the next edge. ir_env and ir_out go to 0 on that edge and no tx_done is produced. tx_abort in IDLE has no effect; a transfer in the same cycle is accepted.
- Carrier: the phase counter restarts at 0 on the first cycle of every mark. In mark cycle k, ir_out = 1 iff (k mod CAR_DIV) < CAR_DIV/2. Every burst therefore starts high.
- During space and IDLE states, ir_out and ir_env are 0.

## Timing
- Reset values: state IDLE, tx_ready 1, tx_done 0, ir_env 0, ir_out 0, all counters 0.
- Reset asserted mid-frame ends the frame immediately; there is no done pulse.
- If the transfer edge is cycle 0, the first LEAD_MARK cycle is cycle 1 and ir_env/ir_out are 1 in cycle 1.
- Each phase occupies exactly its cycle count with no idle cycles between phases.
- tx_done is high in the first cycle after the last STOP_MARK cycle. tx_ready is 1 in that same cycle, so a back-to-back transfer is possible in that cycle.
- tx_ready falls in cycle 1.

## Structure
- Package ir_tx_pkg holds:
  - the state enum ir_tx_state_e
  - function us_to_cycles(clk_hz, us)
  - default phase constants
- Sub-module ir_carrier_gen: carrier phase counter with a restart input and a CAR_DIV parameter; outputs the carrier phase.
- The bit index counter is shared between segments and reloaded at the start of each segment according to MSB_FIRST.

## Test plan
Bench settings: CLK_HZ = 1_000_000 and CARRIER_HZ = 250_000, so 1 cycle = 1 µs and CAR_DIV = 4. SEG0_BITS = 4, SEG1_BITS = 3, and other phase durations at their defaults unless noted.
- Send seg0 = 4'b1010, seg1 = 3'b011, repeat 0 → ir_env edges at cycles 1, 9001, 13501, … tx_done high in cycle 47601 only, with tx_ready 1 in that cycle.
- Same transfer → ir_out during LEAD_MARK is 1,1,0,0 repeating from cycle 1. ir_out is 0 whenever ir_env is 0.
- tx_repeat = 2 → three identical frames, each 47600 cycles, separated by 40000-cycle spaces. A single tx_done in cycle 3·47600 + 2·40000 + 1 = 222801.
- MSB_FIRST = 0 with seg0 = 4'b0001 → first S0 space is 1500 cycles and the next three are 450 cycles.
- tx_abort in cycle 20000 → ir_out and ir_env are 0 and tx_ready is 1 from cycle 20001. No tx_done. A new transfer in cycle 20001 starts LEAD_MARK in cycle 20002.
- rst asserted mid-GAP_SPACE → all outputs at reset values immediately. After release, a new frame runs with correct timing.
